jt10_adpcmb_fetch: RTL

ADPCM-B sample-ROM fetch and nibble buffer. It sits between the ADPCM-B address counter and the ADPCM-B delta decoder. It turns the counter's {addr, nibble_sel, adv, chon} stream into a 4-bit sample stream. Each ROM byte is fetched once and the next byte is prefetched, so the decoder is never stalled by ROM latency.

---
 rtl/jt10_adpcmb_fetch.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/jt10_adpcmb_fetch.sv
// jt10_adpcmb_fetch: ADPCM-B ROM fetch with a current/next byte buffer feeding nibbles to the decoder.
`timescale 1ns/1ps
module jt10_adpcmb_fetch #(
  parameter int AW   = 24,
  parameter int TOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic [AW-1:0] addr,
  input  logic          nibble_sel,
  input  logic          adv,
  input  logic          chon,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  output logic [3:0]    data,
  output logic          data_en,
  output logic          underrun,
  input  logic          clr_err,
  output logic          timeout
);
  localparam int CW = $clog2(TOUT + 1);
  typedef enum logic {IDLE, REQ} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] cur_tag_q, cur_tag_d, nxt_tag_q, nxt_tag_d, rom_addr_q, rom_addr_d;
  logic [7:0]    cur_byte_q, cur_byte_d, nxt_byte_q, nxt_byte_d;
  logic          cur_v_q, cur_v_d, nxt_v_q, nxt_v_d;
  logic          slot_q, slot_d, discard_q, discard_d, chon_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    data_q, data_d;
  logic          data_en_q, underrun_q, underrun_d, timeout_q, timeout_d;
  logic          flush, consume, hit, prom, miss, kill, accept, tout, wr, issue;
  logic [3:0]    cur_nib, nxt_nib;
  // any chon edge empties the buffer; a fetch in flight then completes but is dropped
  assign flush   = chon ^ chon_q;
  assign consume = cen & adv & chon;
  assign hit     = consume & ~flush & cur_v_q & (addr == cur_tag_q);
  assign prom    = consume & ~flush & ~hit & nxt_v_q & (addr == nxt_tag_q);
  assign miss    = consume & ~hit & ~prom;
  assign kill    = flush | miss;
  // the first REQ cycle ignores rom_ok so a leftover ok from the previous fetch is not taken
  assign accept  = (state_q == REQ) & rom_ok & (cnt_q != '0);
  assign tout    = (state_q == REQ) & ~accept & (cnt_q == CW'(TOUT - 1));
  assign wr      = accept & ~discard_q & ~kill;
  assign issue   = (state_q == IDLE) & chon & ~kill & ~prom & (~cur_v_q | ~nxt_v_q);
  assign cur_nib = nibble_sel ? cur_byte_q[3:0] : cur_byte_q[7:4];
  assign nxt_nib = nibble_sel ? nxt_byte_q[3:0] : nxt_byte_q[7:4];
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    slot_d     = slot_q;
    cnt_d      = cnt_q;
    discard_d  = discard_q | kill;
    cur_tag_d  = cur_tag_q;
    cur_byte_d = cur_byte_q;
    cur_v_d    = cur_v_q;
    nxt_tag_d  = nxt_tag_q;
    nxt_byte_d = nxt_byte_q;
    nxt_v_d    = nxt_v_q;
    if (state_q == IDLE) begin
      discard_d = 1'b0;
      if (issue) begin
        state_d    = REQ;
        slot_d     = cur_v_q;
        cnt_d      = '0;
        rom_addr_d = cur_v_q ? cur_tag_q + AW'(1) : addr;
        if (cur_v_q) nxt_tag_d = cur_tag_q + AW'(1);
        else cur_tag_d = addr;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
      if (accept | tout) begin
        state_d   = IDLE;
        discard_d = 1'b0;
      end
    end
    if (wr & ~slot_q) begin
      cur_byte_d = rom_data;
      cur_v_d    = 1'b1;
    end
    if (wr & slot_q) begin
      nxt_byte_d = rom_data;
      nxt_v_d    = 1'b1;
    end
    if (prom) begin
      cur_byte_d = nxt_byte_q;
      cur_tag_d  = nxt_tag_q;
      cur_v_d    = 1'b1;
      nxt_v_d    = 1'b0;
    end
    if (kill) begin
      cur_v_d = 1'b0;
      nxt_v_d = 1'b0;
    end
  end
  assign data_d     = ~chon ? 4'h0 : hit ? cur_nib : prom ? nxt_nib : miss ? 4'h0 : data_q;
  assign underrun_d = miss | (underrun_q & ~clr_err);
  assign timeout_d  = tout | (timeout_q & ~clr_err);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      slot_q     <= 1'b0;
      cnt_q      <= '0;
      discard_q  <= 1'b0;
      cur_tag_q  <= '0;
      cur_byte_q <= '0;
      cur_v_q    <= 1'b0;
      nxt_tag_q  <= '0;
      nxt_byte_q <= '0;
      nxt_v_q    <= 1'b0;
      chon_q     <= 1'b0;
      data_q     <= '0;
      data_en_q  <= 1'b0;
      underrun_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      discard_q  <= discard_d;
      cur_tag_q  <= cur_tag_d;
      cur_byte_q <= cur_byte_d;
      cur_v_q    <= cur_v_d;
      nxt_tag_q  <= nxt_tag_d;
      nxt_byte_q <= nxt_byte_d;
      nxt_v_q    <= nxt_v_d;
      chon_q     <= chon;
      data_q     <= data_d;
      data_en_q  <= consume;
      underrun_q <= underrun_d;
      timeout_q  <= timeout_d;
    end
  end
  assign rom_addr = rom_addr_q;
  assign rom_cs   = (state_q == REQ);
  assign data     = data_q;
  assign data_en  = data_en_q;
  assign underrun = underrun_q;
  assign timeout  = timeout_q;
endmodule
